event_blinker: RTL and testbench

Output-side companion to the push-button debouncer: converts single-cycle event pulses such as `PB_down` or `PB_up` into human-visible LED blinks. Each accepted event produces exactly one blink: LED on for `ON_CYCLES`, then off for `OFF_CYCLES`. Events that arrive during a blink are counted and replayed back-to-back. It sits between debounced button logic, or any strobe source, and a board LED pin.

---
 rtl/event_blinker_pkg.sv | 16 +
 rtl/blink_timer.sv | 33 +++
 rtl/event_blinker.sv | 143 ++++++++++++++
 tb/tb_event_blinker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/event_blinker_pkg.sv
// Shared types and sizing helpers for the event_blinker LED pulse stretcher.
package event_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

  // One timer serves both phases, so it must hold the longer of the two loads.
  function automatic int unsigned timer_width(input int unsigned on_cycles,
                                              input int unsigned off_cycles);
    return $clog2(((on_cycles > off_cycles) ? on_cycles : off_cycles) + 1);
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter that stops at zero; zero flags the last cycle of a phase.
module blink_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle event strobes into visible LED blinks, queueing events that arrive mid-blink.
// Build option: EVENT_BLINKER_OVERFLOW_EN adds a sticky flag for events dropped at counter saturation.
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 5_000_000,
  parameter int unsigned OFF_CYCLES = 5_000_000,
  parameter int unsigned PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_in,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned       TMR_W    = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  blink_state_t      state_q;
  logic              led_q, busy_q;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              tmr_load_c, tmr_zero_c;
  logic [TMR_W-1:0]  tmr_value_c;
  logic              off_end_c, accept_c, consume_c, replay_c;

  blink_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load_c),
    .value (tmr_value_c),
    .zero  (tmr_zero_c)
  );

  // An event landing on the last OFF cycle with nothing queued starts the next blink directly.
  always_comb begin
    tmr_load_c  = 1'b0;
    tmr_value_c = ON_LOAD;
    off_end_c   = (state_q == OFF) && tmr_zero_c;
    consume_c   = off_end_c && (pend_q != '0);
    replay_c    = off_end_c && ((pend_q != '0) || event_in);
    accept_c    = event_in && (state_q != IDLE) && !(off_end_c && (pend_q == '0));

    case (state_q)
      IDLE: begin
        if (event_in) begin
          tmr_load_c  = 1'b1;
          tmr_value_c = ON_LOAD;
        end
      end
      ON: begin
        if (tmr_zero_c) begin
          tmr_load_c  = 1'b1;
          tmr_value_c = OFF_LOAD;
        end
      end
      OFF: begin
        if (replay_c) begin
          tmr_load_c  = 1'b1;
          tmr_value_c = ON_LOAD;
        end
      end
      default: begin
        tmr_load_c = 1'b0;
      end
    endcase

    pend_d = pend_q;
    if (accept_c && !consume_c && (pend_q != PEND_MAX)) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (consume_c && !accept_c) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
    end else begin
      pend_q <= pend_d;
      case (state_q)
        IDLE: begin
          if (event_in) begin
            state_q <= ON;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ON: begin
          if (tmr_zero_c) begin
            state_q <= OFF;
            led_q   <= 1'b0;
          end
        end
        OFF: begin
          if (replay_c) begin
            state_q <= ON;
            led_q   <= 1'b1;
          end else if (tmr_zero_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;

`ifdef EVENT_BLINKER_OVERFLOW_EN
  logic ovf_q;
  logic drop_c;

  assign drop_c = accept_c && !consume_c && (pend_q == PEND_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop_c) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_event_blinker.sv
// Directed bench for event_blinker with ON_CYCLES=3, OFF_CYCLES=2, PEND_W=2; each step checks the state after one edge.
module tb_event_blinker;

  logic       clk = 1'b0;
  logic       rst;
  logic       event_in;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int    tests_run    = 0;
  int    tests_failed = 0;
  string tname;
  int    k;

`ifdef EVENT_BLINKER_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  event_blinker #(
    .ON_CYCLES  (3),
    .OFF_CYCLES (2),
    .PEND_W     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .event_in (event_in),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one edge worth of inputs, then check the registered outputs just after it.
  task automatic cyc(input logic r, input logic ev, input logic e_led,
                     input logic e_busy, input int e_pend);
    rst      = r;
    event_in = ev;
    @(posedge clk);
    #1;
    chk($sformatf("%s.%0d.led", tname, k), 32'(led), 32'(e_led));
    chk($sformatf("%s.%0d.busy", tname, k), 32'(busy), 32'(e_busy));
    chk($sformatf("%s.%0d.pending", tname, k), 32'(pending), 32'(e_pend));
    rst      = 1'b0;
    event_in = 1'b0;
    k++;
  endtask

  task automatic start(input string name);
    tname = name;
    k     = 0;
  endtask

  initial begin
    rst      = 1'b1;
    event_in = 1'b0;

    start("reset");
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset.overflow", 32'(overflow), 32'(0));
    cyc(0, 0, 0, 0, 0);

    // single event: 3 cycles on, 2 off, then idle
    start("single");
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // event on last OFF cycle with nothing queued starts next blink immediately
    start("off_end_p0");
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // events at offsets 0, 2, 3 -> three blinks, pending peaks at 2
    start("three");
    cyc(0, 1, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 1, 1, 1);
    cyc(0, 1, 0, 1, 2);
    cyc(0, 0, 0, 1, 2);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // event on OFF timer-zero with pending=1: consume and accept cancel out
    start("off_end_p1");
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("off_end_p1.overflow", 32'(overflow), 32'(0));

    // five events in a row: pending saturates at 3, fifth is dropped, four blinks
    start("saturate");
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 1);
    cyc(0, 1, 1, 1, 2);
    cyc(0, 1, 0, 1, 3);
    chk("saturate.ovf_before_drop", 32'(overflow), 32'(0));
    cyc(0, 1, 0, 1, 3);
    chk("saturate.ovf_after_drop", 32'(overflow), 32'(OVF_EN));
    cyc(0, 0, 1, 1, 2);
    cyc(0, 0, 1, 1, 2);
    cyc(0, 0, 1, 1, 2);
    cyc(0, 0, 0, 1, 2);
    cyc(0, 0, 0, 1, 2);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("saturate.ovf_sticky", 32'(overflow), 32'(OVF_EN));

    // reset mid-blink with pending=2 aborts and clears everything
    start("rst_mid");
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 1);
    cyc(0, 1, 1, 1, 2);
    cyc(1, 0, 0, 0, 0);
    chk("rst_mid.overflow", 32'(overflow), 32'(0));
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // reset wins over a simultaneous event
    start("rst_ev");
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_ev.overflow", 32'(overflow), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
